pierce_seq_ctrl: RTL and testbench

//  Sequencer that time-shares one WIDTH-bit Pierce (NOR) unit to evaluate eight bitwise ops.

---
 rtl/pierce_seq_pkg.sv | 69 ++++++
 rtl/pierce_arrow.sv | 10 +
 rtl/pierce_nor_vec.sv | 18 +
 rtl/pierce_seq_ctrl.sv | 91 +++++++++
 tb/tb_pierce_seq_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pierce_seq_pkg.sv
// Shared types and microcode for the Pierce-gate sequencer.
// Every derived op is a short chain of NOR steps over scratch registers R0..R3.
package pierce_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_NOR  = 3'd1,
        OP_OR   = 3'd2,
        OP_AND  = 3'd3,
        OP_IMP  = 3'd4,
        OP_NAND = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t src_x;
        reg_idx_t src_y;
        reg_idx_t dst;
        logic     last;
    } uop_t;

    localparam int MAX_STEPS = 6;

    localparam reg_idx_t R0 = 2'd0;
    localparam reg_idx_t R1 = 2'd1;
    localparam reg_idx_t R2 = 2'd2;
    localparam reg_idx_t R3 = 2'd3;

    localparam uop_t UZ = '0;

    function automatic uop_t mk_uop(input reg_idx_t x, input reg_idx_t y,
                                    input reg_idx_t d, input logic l);
        uop_t u;
        u.src_x = x;
        u.src_y = y;
        u.dst   = d;
        u.last  = l;
        return u;
    endfunction

    // Row = op code, column = step; the result always lands in R2.
    localparam uop_t UCODE [8][MAX_STEPS] = '{
        '{mk_uop(R0, R0, R2, 1'b1), UZ, UZ, UZ, UZ, UZ},
        '{mk_uop(R0, R1, R2, 1'b1), UZ, UZ, UZ, UZ, UZ},
        '{mk_uop(R0, R1, R2, 1'b0), mk_uop(R2, R2, R2, 1'b1), UZ, UZ, UZ, UZ},
        '{mk_uop(R0, R0, R2, 1'b0), mk_uop(R1, R1, R3, 1'b0),
          mk_uop(R2, R3, R2, 1'b1), UZ, UZ, UZ},
        '{mk_uop(R0, R0, R2, 1'b0), mk_uop(R2, R1, R2, 1'b0),
          mk_uop(R2, R2, R2, 1'b1), UZ, UZ, UZ},
        '{mk_uop(R0, R0, R2, 1'b0), mk_uop(R1, R1, R3, 1'b0),
          mk_uop(R2, R3, R2, 1'b0), mk_uop(R2, R2, R2, 1'b1), UZ, UZ},
        '{mk_uop(R0, R0, R2, 1'b0), mk_uop(R1, R1, R3, 1'b0),
          mk_uop(R2, R3, R3, 1'b0), mk_uop(R0, R1, R2, 1'b0),
          mk_uop(R2, R3, R2, 1'b1), UZ},
        '{mk_uop(R0, R0, R2, 1'b0), mk_uop(R1, R1, R3, 1'b0),
          mk_uop(R2, R3, R3, 1'b0), mk_uop(R0, R1, R2, 1'b0),
          mk_uop(R2, R3, R2, 1'b0), mk_uop(R2, R2, R2, 1'b1)}
    };

endpackage

// File: rtl/pierce_arrow.sv
// Single-bit Pierce arrow (NOR) cell from the gate library.
module pierce_arrow (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a | b);

endmodule

// File: rtl/pierce_nor_vec.sv
// WIDTH-bit NOR built from per-bit Pierce cells; the sequencer's only compute path.
module pierce_nor_vec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pierce_arrow u_arrow (
            .a(x[i]),
            .b(z[i]),
            .y(y[i])
        );
    end

endmodule

// File: rtl/pierce_seq_ctrl.sv
// Controller that runs one microcoded NOR step per cycle to evaluate eight bitwise ops.
//   state  | meaning
//   S_IDLE | waiting for a request, req_ready=1
//   S_EXEC | stepping through the op's microprogram
//   S_DONE | result in R2 presented until res_ready
module pierce_seq_ctrl
    import pierce_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  op_e              req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    state_t           state, state_nxt;
    op_e              op_q;
    logic [2:0]       step_q;
    logic [WIDTH-1:0] regs [4];
    uop_t             uop;
    logic [WIDTH-1:0] nor_x, nor_y, nor_out;
    logic             accept, exec_en;

    assign uop   = UCODE[op_q][step_q];
    assign nor_x = regs[uop.src_x];
    assign nor_y = regs[uop.src_y];

    pierce_nor_vec #(.WIDTH(WIDTH)) u_nor (
        .x(nor_x),
        .z(nor_y),
        .y(nor_out)
    );

    assign req_ready = (state == S_IDLE);
    assign res_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign res_data  = regs[2];

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        exec_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                if (uop.last) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= OP_NOT;
            step_q <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                regs[0] <= req_a;
                regs[1] <= req_b;
                regs[2] <= '0;
                regs[3] <= '0;
                op_q    <= req_op;
                step_q  <= '0;
            end else if (exec_en) begin
                regs[uop.dst] <= nor_out;
                step_q        <= step_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_pierce_seq_ctrl.sv
// Bench for pierce_seq_ctrl: directed cases plus randomized traffic against a bitwise model.
module tb_pierce_seq_ctrl;
    import pierce_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int NRND  = 1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    op_e              req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] expq [$];
    int         got;
    int         cyc;
    bit         rnd_abort;

    pierce_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0:       return ~a;
            1:       return ~(a | b);
            2:       return a | b;
            3:       return a & b;
            4:       return ~a | b;
            5:       return ~(a & b);
            6:       return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic int steps_of(input int op);
        int tbl [8] = '{1, 1, 2, 3, 3, 4, 5, 6};
        return tbl[op];
    endfunction

    // Issue one request from IDLE, wait for the result, check data and latency.
    task automatic run_op(input int op, input logic [7:0] a, input logic [7:0] b,
                          input string tag);
        int cnt;
        req_op    = op_e'(op);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        chk({tag, "_rdy"}, req_ready, 1);
        step_clk();
        req_valid = 1'b0;
        cnt = 0;
        while (!res_valid && cnt < 20) begin
            step_clk();
            cnt++;
        end
        chk({tag, "_lat"}, cnt, steps_of(op));
        chk({tag, "_data"}, res_data, model(op, a, b));
        if (res_ready) begin
            step_clk();
            chk({tag, "_idle"}, {res_valid, req_ready}, 2'b01);
        end
    endtask

    initial begin
        logic seen;
        int   w;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_NOT;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #3;
        chk("rst_outputs", {res_valid, busy, req_ready, res_data}, {3'b001, 8'h00});
        step_clk();
        step_clk();
        rst_n = 1'b1;
        step_clk();

        // Abort an XOR mid-execution with an asynchronous reset.
        req_op = OP_XOR; req_a = 8'hCA; req_b = 8'h5C; req_valid = 1'b1;
        step_clk();
        req_valid = 1'b0;
        step_clk();
        chk("abort_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {res_valid, busy, res_data}, {2'b00, 8'h00});
        step_clk();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step_clk();
            seen |= res_valid;
        end
        chk("abort_no_result", seen, 0);

        for (int op = 0; op < 8; op++) run_op(op, 8'hCA, 8'h5C, $sformatf("sweep%0d", op));

        // Backpressure: result must hold while res_ready is low.
        res_ready = 1'b0;
        run_op(3, 8'hCA, 8'h5C, "bp");
        repeat (5) begin
            step_clk();
            chk("bp_hold", {res_valid, req_ready, res_data}, {2'b10, 8'h48});
        end
        res_ready = 1'b1;
        step_clk();
        chk("bp_release", {res_valid, req_ready}, 2'b01);

        // Second request raised while the first is still executing.
        res_ready = 1'b0;
        req_op = OP_XOR; req_a = 8'hCA; req_b = 8'h5C; req_valid = 1'b1;
        step_clk();
        req_valid = 1'b0;
        step_clk();
        req_op = OP_NOT; req_a = 8'hFF; req_b = 8'h00; req_valid = 1'b1;
        w = 0;
        while (!res_valid && w < 20) begin
            chk("busy_not_ready", req_ready, 0);
            step_clk();
            w++;
        end
        chk("busy_first_data", res_data, 8'h96);
        step_clk();
        chk("busy_first_held", {res_valid, req_ready, res_data}, {2'b10, 8'h96});
        res_ready = 1'b1;
        step_clk();
        chk("busy_after_hs", {busy, req_ready}, 2'b01);
        step_clk();
        req_valid = 1'b0;
        chk("busy_second_acc", busy, 1);
        step_clk();
        chk("busy_second_data", {res_valid, res_data}, {1'b1, 8'h00});
        step_clk();

        run_op(4, 8'h00, 8'hFF, "edge_imp0");
        run_op(3, 8'h00, 8'hFF, "edge_and0");
        run_op(6, 8'h00, 8'hFF, "edge_xor0");
        run_op(4, 8'hFF, 8'h00, "edge_imp1");
        run_op(7, 8'hFF, 8'h00, "edge_xnor1");

        // Random traffic with stalls on both sides.
        got = 0;
        cyc = 0;
        rnd_abort = 1'b0;
        fork
            begin : drv
                for (int i = 0; i < NRND && !rnd_abort; i++) begin
                    int  gap, ww, op;
                    bit  acc;
                    logic [7:0] a, b;
                    gap = $urandom_range(0, 3);
                    repeat (gap) step_clk();
                    op = $urandom_range(0, 7);
                    a  = 8'($urandom);
                    b  = 8'($urandom);
                    req_op = op_e'(op); req_a = a; req_b = b; req_valid = 1'b1;
                    ww = 0;
                    do begin
                        acc = req_ready;
                        step_clk();
                        ww++;
                    end while (!acc && ww < 200 && !rnd_abort);
                    req_valid = 1'b0;
                    if (acc) expq.push_back(model(op, a, b));
                    else chk("rnd_accept", 0, 1);
                end
            end
            begin : mon
                while (got < NRND && cyc < 60000) begin
                    step_clk();
                    cyc++;
                    res_ready = ($urandom_range(0, 3) != 0);
                    if (res_valid && res_ready) begin
                        if (expq.size() == 0) chk("rnd_extra", 1, 0);
                        else chk("rnd_data", res_data, expq.pop_front());
                        got++;
                    end
                end
                rnd_abort = 1'b1;
            end
        join
        step_clk();
        chk("rnd_count", got, NRND);
        chk("rnd_leftover", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
